// File: rtl/piso_tx_sched.sv
// piso_tx_sched: two-requester round-robin transmit scheduler driving the
// load/shift control (sel/Din) of a WIDTH-bit PISO serializer.
// Each frame is one LOAD cycle followed by WIDTH-1 SHIFT cycles. Frames may
// run back to back with no gap.
// Optional feature macro: PISO_TX_PARITY_EN. It appends one PAR cycle per
// frame and drives par_out/par_slot. Without the macro, both outputs are 0.
module piso_tx_sched #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             piso_sel,
  output logic [WIDTH-1:0] piso_din,
  output logic             frame_start,
  output logic             grant_id,
  output logic             busy,
  output logic             par_out,
  output logic             par_slot
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    PAR   = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             ptr;
  logic             window;
  logic             xfer;
  logic             win_id;
  logic [WIDTH-1:0] win_data;

  // Accept window: open in IDLE and in the final cycle of a frame.
  always_comb begin
    window = 1'b0;
    case (state)
      IDLE:  window = 1'b1;
`ifdef PISO_TX_PARITY_EN
      PAR:   window = 1'b1;
`else
      SHIFT: window = (cnt == '0);
`endif
      default: window = 1'b0;
    endcase
  end

  // Round-robin arbitration. A lone valid always wins. On contention, ptr
  // picks the winner. Both readys are held low while reset is asserted.
  always_comb begin
    req0_ready = reset & window & req0_valid & (~req1_valid | ~ptr);
    req1_ready = reset & window & req1_valid & (~req0_valid |  ptr);
    xfer       = req0_ready | req1_ready;
    win_id     = req1_ready;
    win_data   = req1_ready ? req1_data : req0_data;
  end

`ifndef PISO_TX_PARITY_EN
  assign par_out  = 1'b0;
  assign par_slot = 1'b0;
`endif

  // Frame sequencer. The word is captured on transfer.
  // The final frame cycle either chains directly into LOAD (on a transfer)
  // or falls back to IDLE.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= 1'b0;
      piso_sel    <= 1'b0;
      piso_din    <= '0;
      frame_start <= 1'b0;
      grant_id    <= 1'b0;
      busy        <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_out     <= 1'b0;
      par_slot    <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        piso_din <= win_data;
        grant_id <= win_id;
        ptr      <= ~win_id;
`ifdef PISO_TX_PARITY_EN
        par_out  <= ^win_data;
`endif
      end
      case (state)
        IDLE: begin
          if (xfer) begin
            state       <= LOAD;
            piso_sel    <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          state       <= SHIFT;
          piso_sel    <= 1'b0;
          frame_start <= 1'b0;
          cnt         <= CW'(WIDTH - 2);
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
`ifdef PISO_TX_PARITY_EN
            state    <= PAR;
            par_slot <= 1'b1;
`else
            if (xfer) begin
              state       <= LOAD;
              piso_sel    <= 1'b1;
              frame_start <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`endif
          end
        end
        PAR: begin
`ifdef PISO_TX_PARITY_EN
          par_slot <= 1'b0;
          if (xfer) begin
            state       <= LOAD;
            piso_sel    <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
